// File: rtl/idex_hazard_if.sv
// Decode-to-execute bundle: id_* fields presented by decode and their
// registered idex_* copies produced by the ID/EX stage.
// The master modport is the decode/testbench side. The slave modport is the ID/EX stage.
interface idex_hazard_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4
);
    logic               id_valid;
    logic [4:0]         id_rs1;
    logic [4:0]         id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [4:0]         id_rd;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic [ALUOP_W-1:0] id_alu_op;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic [XLEN-1:0]    id_pc;

    logic               idex_valid;
    logic [4:0]         idex_rs1;
    logic [4:0]         idex_rs2;
    logic               idex_use_rs1;
    logic               idex_use_rs2;
    logic [4:0]         idex_rd;
    logic               idex_reg_write;
    logic               idex_mem_read;
    logic               idex_mem_write;
    logic [ALUOP_W-1:0] idex_alu_op;
    logic [XLEN-1:0]    idex_rs1_data;
    logic [XLEN-1:0]    idex_rs2_data;
    logic [XLEN-1:0]    idex_imm;
    logic [XLEN-1:0]    idex_pc;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, id_mem_write, id_alu_op,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
        input  idex_valid, idex_rs1, idex_rs2, idex_use_rs1, idex_use_rs2, idex_rd,
               idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_op,
               idex_rs1_data, idex_rs2_data, idex_imm, idex_pc
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_reg_write, id_mem_read, id_mem_write, id_alu_op,
               id_rs1_data, id_rs2_data, id_imm, id_pc,
        output idex_valid, idex_rs1, idex_rs2, idex_use_rs1, idex_use_rs2, idex_rd,
               idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_op,
               idex_rs1_data, idex_rs2_data, idex_imm, idex_pc
    );
endinterface

// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// flush and hold. A load-use dependency freezes PC and IF/ID for one cycle
// while a bubble is loaded into ID/EX.
// Optional feature macro: HAZARD_STATS_EN adds saturating stall_count and
// flush_count outputs.
module idex_hazard_stage #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    idex_hazard_if.slave      bus,
    input  logic              flush,
    input  logic              hold,
    output logic              pc_write_en,
    output logic              ifid_write_en,
`ifdef HAZARD_STATS_EN
    output logic [STAT_W-1:0] stall_count,
    output logic [STAT_W-1:0] flush_count,
`endif
    output logic              lu_stall
);

    logic haz;
    logic load_bubble;
    logic capture;

    // Load in EX whose destination is read by the instruction now in decode
    always_comb begin
        haz = bus.idex_valid && bus.idex_mem_read && (bus.idex_rd != 5'd0) && bus.id_valid
              && ((bus.id_use_rs1 && (bus.id_rs1 == bus.idex_rd))
                  || (bus.id_use_rs2 && (bus.id_rs2 == bus.idex_rd)));
        // A flush kills the dependent instruction, so the stall is moot
        lu_stall      = haz && !flush;
        pc_write_en   = !(lu_stall || hold) || flush;
        ifid_write_en = pc_write_en;
        // Priority rst > flush > hold > haz > normal
        load_bubble   = rst || flush || (!hold && haz);
        capture       = !load_bubble && !hold;
    end

    // ID/EX register: bubble, retain or capture decode fields
    always_ff @(posedge clk) begin
        if (load_bubble) begin
            bus.idex_valid     <= 1'b0;
            bus.idex_rs1       <= '0;
            bus.idex_rs2       <= '0;
            bus.idex_use_rs1   <= 1'b0;
            bus.idex_use_rs2   <= 1'b0;
            bus.idex_rd        <= '0;
            bus.idex_reg_write <= 1'b0;
            bus.idex_mem_read  <= 1'b0;
            bus.idex_mem_write <= 1'b0;
            bus.idex_alu_op    <= '0;
            bus.idex_rs1_data  <= '0;
            bus.idex_rs2_data  <= '0;
            bus.idex_imm       <= '0;
            bus.idex_pc        <= '0;
        end else if (capture) begin
            bus.idex_valid     <= bus.id_valid;
            bus.idex_rs1       <= bus.id_rs1;
            bus.idex_rs2       <= bus.id_rs2;
            bus.idex_use_rs1   <= bus.id_use_rs1;
            bus.idex_use_rs2   <= bus.id_use_rs2;
            bus.idex_rd        <= bus.id_rd;
            bus.idex_reg_write <= bus.id_reg_write;
            bus.idex_mem_read  <= bus.id_mem_read;
            bus.idex_mem_write <= bus.id_mem_write;
            bus.idex_alu_op    <= bus.id_alu_op;
            bus.idex_rs1_data  <= bus.id_rs1_data;
            bus.idex_rs2_data  <= bus.id_rs2_data;
            bus.idex_imm       <= bus.id_imm;
            bus.idex_pc        <= bus.id_pc;
        end
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    // Saturating event counters for load-use stalls and flushes
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (lu_stall) stall_count <= sat_inc(stall_count);
            if (flush)    flush_count <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Self-checking bench for idex_hazard_stage: directed scenarios plus a
// randomized run against a behavioural model of the ID/EX register.
module tb_idex_hazard_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use1;
        logic        use2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  alu_op;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst;
    logic   flush;
    logic   hold;
    logic   pc_write_en;
    logic   ifid_write_en;
    logic   lu_stall;
    instr_t in_i;
    instr_t obs;
    int     checks = 0;
    int     failures = 0;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    idex_hazard_if #(.XLEN(32), .ALUOP_W(4)) bus ();

    assign bus.id_valid     = in_i.valid;
    assign bus.id_rs1       = in_i.rs1;
    assign bus.id_rs2       = in_i.rs2;
    assign bus.id_use_rs1   = in_i.use1;
    assign bus.id_use_rs2   = in_i.use2;
    assign bus.id_rd        = in_i.rd;
    assign bus.id_reg_write = in_i.reg_write;
    assign bus.id_mem_read  = in_i.mem_read;
    assign bus.id_mem_write = in_i.mem_write;
    assign bus.id_alu_op    = in_i.alu_op;
    assign bus.id_rs1_data  = in_i.rs1_data;
    assign bus.id_rs2_data  = in_i.rs2_data;
    assign bus.id_imm       = in_i.imm;
    assign bus.id_pc        = in_i.pc;

    assign obs = {bus.idex_valid, bus.idex_rs1, bus.idex_rs2, bus.idex_use_rs1,
                  bus.idex_use_rs2, bus.idex_rd, bus.idex_reg_write, bus.idex_mem_read,
                  bus.idex_mem_write, bus.idex_alu_op, bus.idex_rs1_data,
                  bus.idex_rs2_data, bus.idex_imm, bus.idex_pc};

    idex_hazard_stage #(.XLEN(32), .ALUOP_W(4), .STAT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .flush         (flush),
        .hold          (hold),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
`ifdef HAZARD_STATS_EN
        .stall_count   (stall_count),
        .flush_count   (flush_count),
`endif
        .lu_stall      (lu_stall)
    );

    always #5 clk = ~clk;

    function automatic instr_t rnd_instr();
        instr_t t;
        t.valid     = 1'b1;
        t.rs1       = 5'($urandom);
        t.rs2       = 5'($urandom);
        t.use1      = 1'($urandom);
        t.use2      = 1'($urandom);
        t.rd        = 5'($urandom);
        t.reg_write = 1'($urandom);
        t.mem_read  = 1'b0;
        t.mem_write = 1'($urandom);
        t.alu_op    = 4'($urandom);
        t.rs1_data  = $urandom;
        t.rs2_data  = $urandom;
        t.imm       = $urandom;
        t.pc        = $urandom;
        return t;
    endfunction

    // Does the decode instruction read a register a load in EX has not produced yet?
    function automatic bit model_haz(instr_t ex, instr_t dec);
        if (!ex.valid || !ex.mem_read || ex.rd == 5'd0 || !dec.valid) return 1'b0;
        return (dec.use1 && dec.rs1 == ex.rd) || (dec.use2 && dec.rs2 == ex.rd);
    endfunction

    function automatic instr_t model_next(instr_t ex, instr_t dec, bit r, bit f, bit h);
        if (r || f) return '0;
        if (h) return ex;
        if (model_haz(ex, dec)) return '0;
        return dec;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        in_i = rnd_instr();
        in_i.mem_read = 1'b1;
        tick(); tick();
        checks++; if (obs !== '0) begin failures++; $display("FAIL reset_idex: got %h expected 0", obs); end
        checks++; if (lu_stall !== 1'b0) begin failures++; $display("FAIL reset_lu_stall: got %b expected 0", lu_stall); end
        checks++; if (pc_write_en !== 1'b1) begin failures++; $display("FAIL reset_pc_we: got %b expected 1", pc_write_en); end
        checks++; if (ifid_write_en !== 1'b1) begin failures++; $display("FAIL reset_ifid_we: got %b expected 1", ifid_write_en); end
`ifdef HAZARD_STATS_EN
        checks++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin
            failures++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stall_count, flush_count); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_pass_through();
        in_i = '0;
        in_i.valid = 1'b1; in_i.rs1 = 5'd3; in_i.rs2 = 5'd4; in_i.rd = 5'd5;
        in_i.use1 = 1'b1; in_i.use2 = 1'b1; in_i.reg_write = 1'b1; in_i.rs1_data = 32'h11;
        tick();
        checks++; if (bus.idex_rs1 !== 5'd3) begin failures++; $display("FAIL pass_rs1: got %0d expected 3", bus.idex_rs1); end
        checks++; if (bus.idex_rd !== 5'd5) begin failures++; $display("FAIL pass_rd: got %0d expected 5", bus.idex_rd); end
        checks++; if (bus.idex_rs1_data !== 32'h11) begin failures++; $display("FAIL pass_rs1_data: got %h expected 11", bus.idex_rs1_data); end
        checks++; if (bus.idex_valid !== 1'b1) begin failures++; $display("FAIL pass_valid: got %b expected 1", bus.idex_valid); end
        checks++; if (obs !== in_i) begin failures++; $display("FAIL pass_all: got %h expected %h", obs, in_i); end
    endtask

    task automatic test_load_use();
        in_i = rnd_instr();
        in_i.rd = 5'd5; in_i.mem_read = 1'b1; in_i.reg_write = 1'b1; in_i.mem_write = 1'b0;
        in_i.rs1 = 5'd2; in_i.use1 = 1'b1; in_i.use2 = 1'b0;
        tick();
        in_i = rnd_instr();
        in_i.rs1 = 5'd5; in_i.use1 = 1'b1; in_i.rs2 = 5'd1; in_i.use2 = 1'b1;
        in_i.rd = 5'd6; in_i.reg_write = 1'b1; in_i.mem_write = 1'b0;
        #1;
        checks++; if (lu_stall !== 1'b1) begin failures++; $display("FAIL lu_stall_on: got %b expected 1", lu_stall); end
        checks++; if (pc_write_en !== 1'b0 || ifid_write_en !== 1'b0) begin
            failures++; $display("FAIL lu_enables: got %b%b expected 00", pc_write_en, ifid_write_en); end
        tick();
        checks++; if (bus.idex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble: got %b expected 0", bus.idex_valid); end
        checks++; if (lu_stall !== 1'b0 || pc_write_en !== 1'b1) begin
            failures++; $display("FAIL lu_one_cycle: got stall=%b pc_we=%b expected 0/1", lu_stall, pc_write_en); end
        tick();
        checks++; if (bus.idex_valid !== 1'b1 || bus.idex_rs1 !== 5'd5 || bus.idex_rd !== 5'd6) begin
            failures++; $display("FAIL lu_capture: got v=%b rs1=%0d rd=%0d expected 1/5/6", bus.idex_valid, bus.idex_rs1, bus.idex_rd); end
    endtask

    task automatic test_x0_load();
        in_i = rnd_instr();
        in_i.rd = 5'd0; in_i.mem_read = 1'b1;
        tick();
        in_i = rnd_instr();
        in_i.rs1 = 5'd0; in_i.use1 = 1'b1; in_i.rs2 = 5'd0; in_i.use2 = 1'b1;
        #1;
        checks++; if (lu_stall !== 1'b0 || pc_write_en !== 1'b1) begin
            failures++; $display("FAIL x0_no_stall: got stall=%b pc_we=%b expected 0/1", lu_stall, pc_write_en); end
        tick();
        checks++; if (obs !== in_i) begin failures++; $display("FAIL x0_capture: got %h expected %h", obs, in_i); end
    endtask

    task automatic test_flush_hazard();
`ifdef HAZARD_STATS_EN
        logic [15:0] s0, f0;
`endif
        in_i = rnd_instr();
        in_i.rd = 5'd7; in_i.mem_read = 1'b1;
        tick();
        in_i = rnd_instr();
        in_i.rs1 = 5'd1; in_i.use1 = 1'b0; in_i.rs2 = 5'd7; in_i.use2 = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (lu_stall !== 1'b0) begin failures++; $display("FAIL flush_haz_stall: got %b expected 0", lu_stall); end
        checks++; if (pc_write_en !== 1'b1 || ifid_write_en !== 1'b1) begin
            failures++; $display("FAIL flush_haz_enables: got %b%b expected 11", pc_write_en, ifid_write_en); end
`ifdef HAZARD_STATS_EN
        s0 = stall_count; f0 = flush_count;
`endif
        tick();
        flush = 1'b0;
        checks++; if (obs !== '0) begin failures++; $display("FAIL flush_bubble: got %h expected 0", obs); end
`ifdef HAZARD_STATS_EN
        checks++; if (stall_count !== s0 || flush_count !== f0 + 16'd1) begin
            failures++; $display("FAIL flush_stats: got %0d/%0d expected %0d/%0d", stall_count, flush_count, s0, f0 + 16'd1); end
`endif
    endtask

    task automatic test_hold();
        instr_t a;
        a = rnd_instr();
        in_i = a;
        tick();
        checks++; if (obs !== a) begin failures++; $display("FAIL hold_load: got %h expected %h", obs, a); end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_i = rnd_instr();
            in_i.mem_read = 1'($urandom);
            #1;
            checks++; if (pc_write_en !== 1'b0 || ifid_write_en !== 1'b0) begin
                failures++; $display("FAIL hold_enables: got %b%b expected 00", pc_write_en, ifid_write_en); end
            tick();
            checks++; if (obs !== a) begin failures++; $display("FAIL hold_retain: got %h expected %h", obs, a); end
        end
        hold = 1'b0;
        in_i = rnd_instr();
        #1;
        checks++; if (pc_write_en !== 1'b1) begin failures++; $display("FAIL hold_release_pc_we: got %b expected 1", pc_write_en); end
        tick();
        checks++; if (obs !== in_i) begin failures++; $display("FAIL hold_resume: got %h expected %h", obs, in_i); end
    endtask

    task automatic test_haz_hold();
        instr_t ld;
        ld = rnd_instr();
        ld.rd = 5'd9; ld.mem_read = 1'b1;
        in_i = ld;
        tick();
        in_i = rnd_instr();
        in_i.rs1 = 5'd9; in_i.use1 = 1'b1;
        hold = 1'b1;
        #1;
        checks++; if (lu_stall !== 1'b1 || pc_write_en !== 1'b0) begin
            failures++; $display("FAIL haz_hold_comb: got stall=%b pc_we=%b expected 1/0", lu_stall, pc_write_en); end
        tick();
        checks++; if (obs !== ld) begin failures++; $display("FAIL haz_hold_retain: got %h expected %h", obs, ld); end
        flush = 1'b1;
        #1;
        checks++; if (lu_stall !== 1'b0 || pc_write_en !== 1'b1 || ifid_write_en !== 1'b1) begin
            failures++; $display("FAIL flush_hold_comb: got stall=%b en=%b%b expected 0/11", lu_stall, pc_write_en, ifid_write_en); end
        tick();
        checks++; if (obs !== '0) begin failures++; $display("FAIL flush_hold_bubble: got %h expected 0", obs); end
        flush = 1'b0; hold = 1'b0;
    endtask

    task automatic test_rst_mid_stall();
        in_i = rnd_instr();
        in_i.rd = 5'd5; in_i.mem_read = 1'b1;
        tick();
        in_i = rnd_instr();
        in_i.rs2 = 5'd5; in_i.use2 = 1'b1;
        #1;
        checks++; if (lu_stall !== 1'b1) begin failures++; $display("FAIL rst_mid_pre: got %b expected 1", lu_stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (obs !== '0 || lu_stall !== 1'b0 || pc_write_en !== 1'b1) begin
            failures++; $display("FAIL rst_mid_stall: got %h stall=%b pc_we=%b expected 0/0/1", obs, lu_stall, pc_write_en); end
    endtask

    task automatic test_random();
        instr_t exp;
        bit r, f, h, e_lu, e_en;
        int st_e, fl_e;
        rst = 1'b1; flush = 1'b0; hold = 1'b0;
        tick();
        rst = 1'b0;
        exp = '0; st_e = 0; fl_e = 0;
        for (int i = 0; i < 400; i++) begin
            in_i = rnd_instr();
            in_i.valid = ($urandom_range(0, 9) != 0);
            in_i.rs1 = 5'($urandom_range(0, 3));
            in_i.rs2 = 5'($urandom_range(0, 3));
            in_i.rd = 5'($urandom_range(0, 3));
            in_i.mem_read = 1'($urandom);
            f = ($urandom_range(0, 9) == 0);
            h = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 49) == 0);
            flush = f; hold = h; rst = r;
            #1;
            e_lu = model_haz(exp, in_i) && !f;
            e_en = !(e_lu || h) || f;
            checks++; if (lu_stall !== e_lu) begin failures++; $display("FAIL rnd_lu_stall[%0d]: got %b expected %b", i, lu_stall, e_lu); end
            checks++; if (pc_write_en !== e_en || ifid_write_en !== e_en) begin
                failures++; $display("FAIL rnd_enables[%0d]: got %b%b expected %b", i, pc_write_en, ifid_write_en, e_en); end
            tick();
            exp = model_next(exp, in_i, r, f, h);
            if (r) begin st_e = 0; fl_e = 0; end
            else begin
                if (e_lu && st_e < 65535) st_e++;
                if (f && fl_e < 65535) fl_e++;
            end
            checks++; if (obs !== exp) begin failures++; $display("FAIL rnd_idex[%0d]: got %h expected %h", i, obs, exp); end
`ifdef HAZARD_STATS_EN
            checks++; if (int'(stall_count) != st_e || int'(flush_count) != fl_e) begin
                failures++; $display("FAIL rnd_stats[%0d]: got %0d/%0d expected %0d/%0d", i, stall_count, flush_count, st_e, fl_e); end
`endif
        end
        rst = 1'b0; flush = 1'b0; hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_load_use();
        test_x0_load();
        test_flush_hazard();
        test_hold();
        test_haz_hold();
        test_rst_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
